// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: mnemonics, opcodes, loader states and error codes.
// Used by the main decoder and by the program loader.
package mips_pkg;

    typedef enum logic [3:0] {
        M_RTYPE = 4'd0,
        M_LW    = 4'd1,
        M_LH    = 4'd2,
        M_LB    = 4'd3,
        M_LBU   = 4'd4,
        M_SW    = 4'd5,
        M_SH    = 4'd6,
        M_SB    = 4'd7,
        M_BEQ   = 4'd8,
        M_BNE   = 4'd9,
        M_ADDI  = 4'd10,
        M_ORI   = 4'd11,
        M_J     = 4'd12
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Loader states kept as plain 2-bit codes so legacy decoders of the state bus still match.
    typedef logic [1:0] ldr_state_t;
    localparam ldr_state_t LDR_IDLE = 2'd0;
    localparam ldr_state_t LDR_RUN  = 2'd1;
    localparam ldr_state_t LDR_DONE = 2'd2;
    localparam ldr_state_t LDR_ERR  = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

endpackage

// File: rtl/instr_enc_comb.sv
// Combinational MIPS assembler: mnemonic plus fields -> 32-bit word and legality flag.
// Fields not used by a format are ignored.
module instr_enc_comb
    import mips_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic [31:0] word
);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (mnem)
            M_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            M_LW:    word = {OP_LW,   rs, rt, imm};
            M_LH:    word = {OP_LH,   rs, rt, imm};
            M_LB:    word = {OP_LB,   rs, rt, imm};
            M_LBU:   word = {OP_LBU,  rs, rt, imm};
            M_SW:    word = {OP_SW,   rs, rt, imm};
            M_SH:    word = {OP_SH,   rs, rt, imm};
            M_SB:    word = {OP_SB,   rs, rt, imm};
            M_BEQ:   word = {OP_BEQ,  rs, rt, imm};
            M_BNE:   word = {OP_BNE,  rs, rt, imm};
            M_ADDI:  word = {OP_ADDI, rs, rt, imm};
            M_ORI:   word = {OP_ORI,  rs, rt, imm};
            M_J:     word = {OP_J, target};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-path program loader: encodes symbolic instruction beats and writes them
// sequentially into imem through a held write/ack handshake.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    ldr_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic              last_pend;
    logic              ill_pend;
    logic              enc_legal;
    logic [31:0]       enc_word;
    logic              ack;
    logic              accept;
    logic [ADDR_W:0]   count_next;

    instr_enc_comb u_enc (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .legal  (enc_legal),
        .word   (enc_word)
    );

    assign ack        = imem_we & imem_ack;
    assign count_next = count + (ADDR_W+1)'(ack);
    // Stop accepting once a terminating beat (last or illegal) is waiting on its pending write.
    assign in_ready   = (state == LDR_RUN) & ~ill_pend & ~last_pend
                      & (~imem_we | imem_ack) & (count_next < DEPTH_C);
    assign accept     = in_valid & in_ready;
    assign busy       = (state == LDR_RUN);
    assign imem_addr  = ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LDR_IDLE;
            ptr       <= '0;
            count     <= '0;
            imem_we   <= 1'b0;
            imem_wd   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            last_pend <= 1'b0;
            ill_pend  <= 1'b0;
        end else begin
            case (state)
                LDR_RUN: begin
                    if (ack) begin
                        ptr     <= ptr + ADDR_W'(1);
                        count   <= count_next;
                        imem_we <= 1'b0;
                    end
                    if (accept) begin
                        if (enc_legal) begin
                            imem_we   <= 1'b1;
                            imem_wd   <= enc_word;
                            last_pend <= in_last;
                        end else if (imem_we && !imem_ack) begin
                            ill_pend <= 1'b1;
                        end else begin
                            state    <= LDR_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end
                    end
                    if (ack && ill_pend) begin
                        state    <= LDR_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_ILLEGAL;
                        ill_pend <= 1'b0;
                    end
                    if (ack && last_pend) begin
                        state     <= LDR_DONE;
                        done      <= 1'b1;
                        last_pend <= 1'b0;
                    end
                    if (count == DEPTH_C && !imem_we && in_valid) begin
                        state    <= LDR_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_OVERFLOW;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= LDR_RUN;
                        ptr       <= '0;
                        count     <= '0;
                        imem_we   <= 1'b0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                        last_pend <= 1'b0;
                        ill_pend  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: encoding table, hand-written handshake corner cases,
// and random programs checked against a word-list model of the loader.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_ready;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              imem_ack;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd), .imem_ack(imem_ack),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] word;
        int unsigned cyc;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned wait_cnt = 0;
    int unsigned ack_delay = 0;
    int          outcome;
    wr_t         seen[$];
    wr_t         exp_q[$];
    beat_t       prog[$];
    int unsigned op_of [13] = '{0, 35, 33, 32, 36, 43, 41, 40, 4, 5, 8, 13, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: log a write accepted this cycle, then move the memory's ack model.
    task automatic tick();
        wr_t w;
        if (imem_we === 1'b1 && imem_ack === 1'b1) begin
            w.addr = int'(imem_addr);
            w.word = imem_wd;
            w.cyc  = cyc;
            seen.push_back(w);
        end
        @(negedge clk);
        cyc++;
        if (reset !== 1'b1 || imem_we !== 1'b1) begin
            wait_cnt = 0;
            imem_ack = 1'b0;
        end else if (imem_ack) begin
            imem_ack = (ack_delay == 0);
            wait_cnt = (ack_delay == 0) ? 0 : 1;
        end else if (wait_cnt >= ack_delay) begin
            imem_ack = 1'b1;
        end else begin
            wait_cnt++;
        end
        #1;
    endtask

    task automatic drive(input beat_t b);
        in_mnem = b.mnem; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd; in_shamt = b.shamt;
        in_funct = b.funct; in_imm = b.imm; in_target = b.target; in_last = b.last;
    endtask

    task automatic do_reset();
        beat_t z;
        z = '{default: '0};
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ack = 1'b0; wait_cnt = 0;
        drive(z);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic start_prog();
        seen.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_prog(input bit wait_end);
        int n;
        for (int i = 0; i < prog.size(); i++) begin
            drive(prog[i]);
            in_valid = 1'b1;
            n = 0;
            while (in_ready !== 1'b1 && done !== 1'b1 && err !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            if (in_ready === 1'b1) tick();
            else break;
        end
        in_valid = 1'b0;
        n = 0;
        while (wait_end && done !== 1'b1 && err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic beat_t mk(input int m, input int rs, input int rt, input int rd,
                                 input int sh, input int fn, input int imm, input int tg,
                                 input bit last);
        beat_t b;
        b.mnem = 4'(m); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.shamt = 5'(sh);
        b.funct = 6'(fn); b.imm = 16'(imm); b.target = 26'(tg); b.last = last;
        return b;
    endfunction

    // Reference assembler built from opcode numbers and field weights.
    function automatic logic [32:0] ref_word(input beat_t b);
        logic [63:0] w;
        if (b.mnem > 4'd12) return 33'd0;
        if (b.mnem == 4'd0)
            w = 64'(b.rs) * (64'd1 << 21) + 64'(b.rt) * (64'd1 << 16) + 64'(b.rd) * (64'd1 << 11)
              + 64'(b.shamt) * 64'd64 + 64'(b.funct);
        else if (b.mnem == 4'd12)
            w = 64'(op_of[12]) * (64'd1 << 26) + 64'(b.target);
        else
            w = 64'(op_of[b.mnem]) * (64'd1 << 26) + 64'(b.rs) * (64'd1 << 21)
              + 64'(b.rt) * (64'd1 << 16) + 64'(b.imm);
        return {1'b1, w[31:0]};
    endfunction

    // outcome: 0 still loading, 1 done, 2 illegal, 3 overflow
    task automatic build_expect();
        logic [32:0] r;
        wr_t         w;
        int          n;
        exp_q.delete();
        n = 0;
        outcome = 0;
        for (int i = 0; i < prog.size(); i++) begin
            r = ref_word(prog[i]);
            if (n == DEPTH) begin outcome = 3; break; end
            if (!r[32]) begin outcome = 2; break; end
            w.addr = n; w.word = r[31:0]; w.cyc = 0;
            exp_q.push_back(w);
            n++;
            if (prog[i].last) begin outcome = 1; break; end
        end
    endtask

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    len;

        do_reset();
        chk("rst we", imem_we, 0);
        chk("rst addr", imem_addr, 0);
        chk("rst wd", imem_wd, 0);
        chk("rst ready", in_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst code", err_code, 0);
        chk("rst count", count, 0);

        // encoding table; unused fields carry junk that must not leak into the word
        vecs.push_back('{mk(10, 0, 8, 31, 17, 63, 5, 26'h3ffffff, 1), 32'h20080005});
        vecs.push_back('{mk(1, 29, 8, 7, 3, 5, 4, 26'h155, 1), 32'h8FA80004});
        vecs.push_back('{mk(0, 8, 9, 10, 0, 32, 16'hbeef, 26'h2aa, 1), 32'h01095020});
        vecs.push_back('{mk(12, 31, 31, 31, 31, 63, 16'hffff, 26'h10, 1), 32'h08000010});
        vecs.push_back('{mk(9, 8, 0, 5, 9, 1, 16'hffff, 0, 1), 32'h1500FFFF});
        vecs.push_back('{mk(4, 4, 2, 3, 1, 2, 1, 26'h1234, 1), 32'h90820001});
        vecs.push_back('{mk(5, 29, 31, 1, 1, 1, 8, 1, 1), 32'hAFBF0008});
        vecs.push_back('{mk(11, 0, 1, 2, 2, 2, 16'habcd, 2, 1), 32'h3401ABCD});
        vecs.push_back('{mk(8, 1, 2, 3, 3, 3, 16'hfffe, 3, 1), 32'h1022FFFE});
        vecs.push_back('{mk(7, 3, 4, 5, 4, 4, 16'h0010, 4, 1), 32'hA0640010});
        vecs.push_back('{mk(2, 5, 6, 7, 5, 5, 2, 5, 1), 32'h84A60002});
        vecs.push_back('{mk(3, 7, 8, 9, 6, 6, 16'h7fff, 6, 1), 32'h80E87FFF});
        vecs.push_back('{mk(6, 9, 10, 11, 7, 7, 6, 7, 1), 32'hA52A0006});
        vecs.push_back('{mk(0, 31, 0, 17, 31, 6'h2a, 0, 0, 1), 32'h03E08FEA});
        for (int i = 0; i < vecs.size(); i++) begin
            ack_delay = i % 3;
            start_prog();
            prog.delete();
            prog.push_back(vecs[i].b);
            run_prog(1);
            chk($sformatf("tbl%0d nwr", i), seen.size(), 1);
            if (seen.size() > 0) begin
                chk($sformatf("tbl%0d word", i), seen[0].word, vecs[i].word);
                chk($sformatf("tbl%0d addr", i), seen[0].addr, 0);
            end
            chk($sformatf("tbl%0d done", i), done, 1);
        end

        // three words back to back with ack tied high
        ack_delay = 0;
        start_prog();
        prog.delete();
        prog.push_back(mk(10, 0, 8, 0, 0, 0, 5, 0, 0));
        prog.push_back(mk(1, 29, 8, 0, 0, 0, 4, 0, 0));
        prog.push_back(mk(0, 8, 9, 10, 0, 32, 0, 0, 0));
        run_prog(0);
        repeat (2) tick();
        chk("cov nwr", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("cov w0", {seen[0].addr[7:0], seen[0].word}, {8'd0, 32'h20080005});
            chk("cov w1", {seen[1].addr[7:0], seen[1].word}, {8'd1, 32'h8FA80004});
            chk("cov w2", {seen[2].addr[7:0], seen[2].word}, {8'd2, 32'h01095020});
            chk("cov gap01", seen[1].cyc - seen[0].cyc, 1);
            chk("cov gap12", seen[2].cyc - seen[1].cyc, 1);
        end
        chk("cov count", count, 3);
        chk("cov busy", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cov start ignored count", count, 3);
        chk("cov start ignored addr", imem_addr, 3);
        do_reset();

        // last beat and done
        start_prog();
        prog.delete();
        prog.push_back(mk(12, 0, 0, 0, 0, 0, 0, 26'h10, 0));
        prog.push_back(mk(9, 8, 0, 0, 0, 0, 16'hffff, 0, 1));
        run_prog(1);
        chk("last nwr", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("last w0", {seen[0].addr[7:0], seen[0].word}, {8'd0, 32'h08000010});
            chk("last w1", {seen[1].addr[7:0], seen[1].word}, {8'd1, 32'h1500FFFF});
        end
        chk("last done", done, 1);
        chk("last busy", busy, 0);
        chk("last ready", in_ready, 0);
        chk("last count", count, 2);

        // backpressure: ack arrives on the fourth cycle of the write
        ack_delay = 3;
        start_prog();
        drive(mk(4, 4, 2, 0, 0, 0, 1, 0, 1));
        in_valid = 1'b1;
        chk("bp ready before", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp we c%0d", k), imem_we, 1);
            chk($sformatf("bp wd c%0d", k), imem_wd, 32'h90820001);
            chk($sformatf("bp addr c%0d", k), imem_addr, 0);
            chk($sformatf("bp ready c%0d", k), in_ready, 0);
            tick();
        end
        chk("bp nwr", seen.size(), 1);
        chk("bp we after", imem_we, 0);
        chk("bp done", done, 1);

        // illegal mnemonic after one legal beat
        ack_delay = 0;
        start_prog();
        prog.delete();
        prog.push_back(mk(10, 1, 2, 0, 0, 0, 3, 0, 0));
        prog.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0));
        run_prog(1);
        chk("ill err", err, 1);
        chk("ill code", err_code, 1);
        chk("ill done", done, 0);
        repeat (2) tick();
        chk("ill nwr", seen.size(), 1);
        chk("ill count", count, 1);
        chk("ill ready", in_ready, 0);

        // overflow: DEPTH+1 beats with no last
        start_prog();
        prog.delete();
        for (int i = 0; i < DEPTH + 1; i++) prog.push_back(mk(11, 0, 1, 0, 0, 0, i, 0, 0));
        run_prog(1);
        chk("ovf nwr", seen.size(), DEPTH);
        for (int i = 0; i < seen.size(); i++) chk($sformatf("ovf addr%0d", i), seen[i].addr, i);
        chk("ovf err", err, 1);
        chk("ovf code", err_code, 2);
        chk("ovf count", count, DEPTH);
        chk("ovf ready", in_ready, 0);
        start_prog();
        chk("restart err", err, 0);
        chk("restart code", err_code, 0);
        chk("restart busy", busy, 1);
        chk("restart count", count, 0);
        prog.delete();
        prog.push_back(mk(5, 29, 31, 0, 0, 0, 8, 0, 1));
        run_prog(1);
        chk("restart nwr", seen.size(), 1);
        if (seen.size() == 1) chk("restart addr", seen[0].addr, 0);
        chk("restart done", done, 1);

        // asynchronous reset while a write is held
        start_prog();
        prog.delete();
        prog.push_back(mk(10, 0, 8, 0, 0, 0, 5, 0, 0));
        run_prog(0);
        repeat (2) tick();
        chk("mid count before", count, 1);
        ack_delay = 50;
        drive(mk(1, 29, 8, 0, 0, 0, 4, 0, 0));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid we before", imem_we, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid we async", imem_we, 0);
        chk("mid count async", count, 0);
        chk("mid busy async", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        ack_delay = 0;
        #1;
        tick();
        chk("mid busy after", busy, 0);
        chk("mid ready after", in_ready, 0);
        chk("mid count after", count, 0);

        // random programs against the word-list model
        for (int t = 0; t < 40; t++) begin
            prog.delete();
            len = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < len; i++) begin
                b.mnem = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15))
                                                     : 4'($urandom_range(0, 12));
                b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom);
                b.shamt = 5'($urandom); b.funct = 6'($urandom); b.imm = 16'($urandom);
                b.target = 26'($urandom);
                b.last = (i == len - 1 && len <= DEPTH) || ($urandom_range(0, 9) == 0);
                prog.push_back(b);
            end
            ack_delay = $urandom_range(0, 3);
            build_expect();
            start_prog();
            run_prog(1);
            chk($sformatf("rnd%0d nwr", t), seen.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
                chk($sformatf("rnd%0d addr%0d", t, i), seen[i].addr, exp_q[i].addr);
                chk($sformatf("rnd%0d word%0d", t, i), seen[i].word, exp_q[i].word);
            end
            chk($sformatf("rnd%0d done", t), done, outcome == 1);
            chk($sformatf("rnd%0d err", t), err, outcome >= 2);
            chk($sformatf("rnd%0d code", t), err_code,
                (outcome == 2) ? 1 : (outcome == 3) ? 2 : 0);
            chk($sformatf("rnd%0d count", t), count, exp_q.size());
            chk($sformatf("rnd%0d busy", t), busy, 0);
            if (busy === 1'b1) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
